// File: rtl/fetch_inst_queue_if.sv
// fetch_inst_queue_if: fetch-side write bundle, decode-side read bundle and queue status
interface fetch_inst_queue_if #(
    parameter int PKT_W = 133,
    parameter int DEPTH = 16
);
    logic                     flush_i;
    logic                     fs2Ready_i;
    logic                     inst0Valid_i;
    logic                     inst1Valid_i;
    logic                     inst2Valid_i;
    logic                     inst3Valid_i;
    logic [PKT_W-1:0]         inst0Packet_i;
    logic [PKT_W-1:0]         inst1Packet_i;
    logic [PKT_W-1:0]         inst2Packet_i;
    logic [PKT_W-1:0]         inst3Packet_i;
    logic                     decodeReady_i;
    logic [2:0]               frontEndWidth_i;
    logic                     fetchqFull_o;
    logic                     fetchqEmpty_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     inst0Valid_o;
    logic                     inst1Valid_o;
    logic                     inst2Valid_o;
    logic                     inst3Valid_o;
    logic [PKT_W-1:0]         inst0Packet_o;
    logic [PKT_W-1:0]         inst1Packet_o;
    logic [PKT_W-1:0]         inst2Packet_o;
    logic [PKT_W-1:0]         inst3Packet_o;

    modport master (
        output flush_i, fs2Ready_i,
        output inst0Valid_i, inst1Valid_i, inst2Valid_i, inst3Valid_i,
        output inst0Packet_i, inst1Packet_i, inst2Packet_i, inst3Packet_i,
        output decodeReady_i, frontEndWidth_i,
        input  fetchqFull_o, fetchqEmpty_o, count_o,
        input  inst0Valid_o, inst1Valid_o, inst2Valid_o, inst3Valid_o,
        input  inst0Packet_o, inst1Packet_o, inst2Packet_o, inst3Packet_o
    );

    modport slave (
        input  flush_i, fs2Ready_i,
        input  inst0Valid_i, inst1Valid_i, inst2Valid_i, inst3Valid_i,
        input  inst0Packet_i, inst1Packet_i, inst2Packet_i, inst3Packet_i,
        input  decodeReady_i, frontEndWidth_i,
        output fetchqFull_o, fetchqEmpty_o, count_o,
        output inst0Valid_o, inst1Valid_o, inst2Valid_o, inst3Valid_o,
        output inst0Packet_o, inst1Packet_o, inst2Packet_o, inst3Packet_o
    );
endinterface

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: compacting circular instruction queue between fetch stage 2 and decode; FETCHQ_STATS_EN adds full/empty cycle counters
module fetch_inst_queue #(
    parameter int PKT_W = 133,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    fetch_inst_queue_if.slave q
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0] fullCycles_o,
    output logic [31:0] emptyCycles_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PKT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       vld_in, vld_out;
    logic [PKT_W-1:0] pkt_in [4];
    logic [PKT_W-1:0] pkt_out [4];
    logic [2:0]       w, nr, nw;
    logic             full, push, pop;

    assign vld_in    = {q.inst3Valid_i, q.inst2Valid_i, q.inst1Valid_i, q.inst0Valid_i};
    assign pkt_in[0] = q.inst0Packet_i;
    assign pkt_in[1] = q.inst1Packet_i;
    assign pkt_in[2] = q.inst2Packet_i;
    assign pkt_in[3] = q.inst3Packet_i;

    // Width decode, push/pop qualification and next pointer/count state; flush wins over everything
    always_comb begin
        w       = (q.frontEndWidth_i == 3'd0 || q.frontEndWidth_i > 3'd4) ? 3'd4 : q.frontEndWidth_i;
        nr      = (count_q < CW'(w)) ? count_q[2:0] : w;
        full    = count_q > CW'(DEPTH - 4);
        push    = q.fs2Ready_i & ~full & ~q.flush_i;
        pop     = q.decodeReady_i & ~q.flush_i;
        nw      = 3'(vld_in[0]) + 3'(vld_in[1]) + 3'(vld_in[2]) + 3'(vld_in[3]);
        head_d  = q.flush_i ? '0 : head_q + (pop ? AW'(nr) : '0);
        tail_d  = q.flush_i ? '0 : tail_q + (push ? AW'(nw) : '0);
        count_d = q.flush_i ? '0 : count_q + (push ? CW'(nw) : '0) - (pop ? CW'(nr) : '0);
    end

    // Compact valid slots in slot order into consecutive entries starting at tail
    always_comb begin
        logic [2:0] off;
        mem_d = mem_q;
        off   = '0;
        for (int k = 0; k < 4; k++) begin
            if (push && vld_in[k]) begin
                mem_d[tail_q + AW'(off)] = pkt_in[k];
                off = off + 3'd1;
            end
        end
    end

    // Queue control state
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Packet storage needs no reset: presentation is gated by count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar i = 0; i < 4; i++) begin : g_out
        assign pkt_out[i] = mem_q[head_q + AW'(i)];
        assign vld_out[i] = 3'(i) < nr;
    end

    assign q.fetchqFull_o  = full;
    assign q.fetchqEmpty_o = count_q == '0;
    assign q.count_o       = count_q;
    assign q.inst0Valid_o  = vld_out[0];
    assign q.inst1Valid_o  = vld_out[1];
    assign q.inst2Valid_o  = vld_out[2];
    assign q.inst3Valid_o  = vld_out[3];
    assign q.inst0Packet_o = pkt_out[0];
    assign q.inst1Packet_o = pkt_out[1];
    assign q.inst2Packet_o = pkt_out[2];
    assign q.inst3Packet_o = pkt_out[3];

`ifdef FETCHQ_STATS_EN
    logic [31:0] full_cycles_q, full_cycles_d, empty_cycles_q, empty_cycles_d;

    // Saturating occupancy statistics; flush deliberately leaves them alone
    always_comb begin
        full_cycles_d  = (full & q.fs2Ready_i & ~&full_cycles_q) ? full_cycles_q + 32'd1 : full_cycles_q;
        empty_cycles_d = (count_q == '0 && ~&empty_cycles_q) ? empty_cycles_q + 32'd1 : empty_cycles_q;
    end

    // Statistics registers clear on reset only
    always_ff @(posedge clk) begin
        if (reset) begin
            full_cycles_q  <= '0;
            empty_cycles_q <= '0;
        end else begin
            full_cycles_q  <= full_cycles_d;
            empty_cycles_q <= empty_cycles_d;
        end
    end

    assign fullCycles_o  = full_cycles_q;
    assign emptyCycles_o = empty_cycles_q;
`endif
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb_fetch_inst_queue: scoreboard bench for fetch_inst_queue; covers FETCHQ_STATS_EN when defined
module tb_fetch_inst_queue;
    localparam int PKT_W = 133;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [PKT_W-1:0] sb [$];

    always #5 clk = ~clk;

    fetch_inst_queue_if #(.PKT_W(PKT_W), .DEPTH(DEPTH)) qif ();

`ifdef FETCHQ_STATS_EN
    logic [31:0] full_cycles, empty_cycles;
    fetch_inst_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .q(qif),
        .fullCycles_o(full_cycles), .emptyCycles_o(empty_cycles)
    );
`else
    fetch_inst_queue #(.PKT_W(PKT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .q(qif)
    );
`endif

    task automatic check(input string tag, input logic [PKT_W-1:0] got, input logic [PKT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [PKT_W-1:0] rnd_pkt();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[PKT_W-1:0];
    endfunction

    function automatic logic [3:0] vo();
        return {qif.inst3Valid_o, qif.inst2Valid_o, qif.inst1Valid_o, qif.inst0Valid_o};
    endfunction

    function automatic logic [PKT_W-1:0] po(input int k);
        return k == 0 ? qif.inst0Packet_o : k == 1 ? qif.inst1Packet_o :
               k == 2 ? qif.inst2Packet_o : qif.inst3Packet_o;
    endfunction

    function automatic int width_of(input logic [2:0] fe);
        return (fe == 3'd0 || fe > 3'd4) ? 4 : int'(fe);
    endfunction

    // Compare every visible output against the scoreboard contents
    task automatic compare_outputs(input logic [2:0] fe);
        int n;
        n = sb.size() < width_of(fe) ? sb.size() : width_of(fe);
        check("count", PKT_W'(qif.count_o), PKT_W'(sb.size()));
        check("full", PKT_W'(qif.fetchqFull_o), PKT_W'(sb.size() > DEPTH - 4));
        check("empty", PKT_W'(qif.fetchqEmpty_o), PKT_W'(sb.size() == 0));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("vld%0d", k), PKT_W'(vo()[k]), PKT_W'(k < n));
            if (k < n) check($sformatf("pkt%0d", k), po(k), sb[k]);
        end
    endtask

    // One cycle: drive, compare current outputs, update model, advance to next negedge
    task automatic step(input bit fs2, input logic [3:0] v, input bit dr, input logic [2:0] fe, input bit fl);
        logic [PKT_W-1:0] p [4];
        int n;
        bit fullm;
        for (int k = 0; k < 4; k++) p[k] = rnd_pkt();
        qif.fs2Ready_i      = fs2;
        qif.inst0Valid_i    = v[0];
        qif.inst1Valid_i    = v[1];
        qif.inst2Valid_i    = v[2];
        qif.inst3Valid_i    = v[3];
        qif.inst0Packet_i   = p[0];
        qif.inst1Packet_i   = p[1];
        qif.inst2Packet_i   = p[2];
        qif.inst3Packet_i   = p[3];
        qif.decodeReady_i   = dr;
        qif.frontEndWidth_i = fe;
        qif.flush_i         = fl;
        #1;
        compare_outputs(fe);
        n = sb.size() < width_of(fe) ? sb.size() : width_of(fe);
        fullm = sb.size() > DEPTH - 4;
        if (fl) sb.delete();
        else begin
            if (dr) repeat (n) void'(sb.pop_front());
            if (fs2 && !fullm) for (int k = 0; k < 4; k++) if (v[k]) sb.push_back(p[k]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        qif.fs2Ready_i = 1'b0;
        qif.inst0Valid_i = 1'b0;
        qif.inst1Valid_i = 1'b0;
        qif.inst2Valid_i = 1'b0;
        qif.inst3Valid_i = 1'b0;
        qif.inst0Packet_i = '0;
        qif.inst1Packet_i = '0;
        qif.inst2Packet_i = '0;
        qif.inst3Packet_i = '0;
        qif.decodeReady_i = 1'b0;
        qif.frontEndWidth_i = 3'd4;
        qif.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", PKT_W'(vo()), PKT_W'(0));
        check("rst_full", PKT_W'(qif.fetchqFull_o), PKT_W'(0));
        check("rst_empty", PKT_W'(qif.fetchqEmpty_o), PKT_W'(1));
        check("rst_count", PKT_W'(qif.count_o), PKT_W'(0));
`ifdef FETCHQ_STATS_EN
        check("rst_fullcyc", PKT_W'(full_cycles), PKT_W'(0));
        check("rst_emptycyc", PKT_W'(empty_cycles), PKT_W'(0));
`endif
        reset = 1'b0;
        sb.delete();
    endtask

    initial begin
        do_reset();
        // basic latency
        step(1, 4'hF, 0, 4, 0);
        check("basic_count", PKT_W'(qif.count_o), PKT_W'(4));
        step(0, 4'h0, 1, 4, 0);
        check("basic_drained", PKT_W'(qif.fetchqEmpty_o), PKT_W'(1));
        // empty pop has no effect
        step(0, 4'h0, 1, 4, 0);
        check("empty_pop", PKT_W'(qif.count_o), PKT_W'(0));
        // compaction: slots 0,2,3 valid
        step(1, 4'b1101, 0, 4, 0);
        check("cmp_count", PKT_W'(qif.count_o), PKT_W'(3));
        check("cmp_vld3", PKT_W'(qif.inst3Valid_o), PKT_W'(0));
        step(0, 4'h0, 1, 4, 0);
        // full and wrap: tail sits at 7, fill to 16
        repeat (3) step(1, 4'hF, 0, 4, 0);
        check("fill12_full", PKT_W'(qif.fetchqFull_o), PKT_W'(0));
        step(1, 4'hF, 0, 4, 0);
        check("full_count", PKT_W'(qif.count_o), PKT_W'(16));
        check("full_flag", PKT_W'(qif.fetchqFull_o), PKT_W'(1));
        step(1, 4'hF, 0, 4, 0);
        check("refused", PKT_W'(qif.count_o), PKT_W'(16));
        repeat (4) step(0, 4'h0, 1, 4, 0);
        // simultaneous push and pop, then with flush
        step(1, 4'hF, 0, 4, 0);
        step(1, 4'b0011, 0, 4, 0);
        step(1, 4'b0111, 1, 4, 0);
        check("pushpop_count", PKT_W'(qif.count_o), PKT_W'(5));
        step(1, 4'b0001, 0, 4, 0);
        step(1, 4'b0111, 1, 4, 1);
        check("flush_count", PKT_W'(qif.count_o), PKT_W'(0));
        check("flush_vld", PKT_W'(vo()), PKT_W'(0));
        // width control
        step(1, 4'hF, 0, 4, 0);
        step(1, 4'b0001, 0, 4, 0);
        step(0, 4'h0, 0, 2, 0);
        step(0, 4'h0, 1, 2, 0);
        check("w2_count", PKT_W'(qif.count_o), PKT_W'(3));
        step(1, 4'b0011, 0, 2, 0);
        step(0, 4'h0, 1, 7, 0);
        check("w7_count", PKT_W'(qif.count_o), PKT_W'(1));
        // random traffic
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
                 3'($urandom_range(0, 7)), $urandom_range(0, 31) == 0);
`ifdef FETCHQ_STATS_EN
        do_reset();
        repeat (4) step(1, 4'hF, 0, 4, 0);
        repeat (10) step(1, 4'hF, 0, 4, 0);
        check("full_cycles", PKT_W'(full_cycles), PKT_W'(10));
        check("empty_cycles", PKT_W'(empty_cycles), PKT_W'(1));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_inst_queue.md
# fetch_inst_queue

Instruction queue between fetch stage 2 and decode. Accepts up to four pre-decoded instruction packets per cycle, each with its own valid bit, and compacts the valid ones into a circular buffer in program order. Presents up to four oldest entries per cycle to decode. Isolates fetch from decode back-pressure and absorbs branch-truncated fetch bundles.

## Interface
- `PKT_W`, default 133: packet width (`SIZE_INSTRUCTION + 2*SIZE_PC + SIZE_CTI_LOG + 1`).
- `DEPTH`, default 16: entry count. Must be a power of two, ≥ 8.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `flush_i` input 1: discard all contents. Asserted on recovery from execute or from stage-2 redirect.
- `fs2Ready_i` input 1: the fetch bundle on the write ports is meaningful this cycle.
- `inst0Valid_i`..`inst3Valid_i` input 1 each: per-slot valid. Slot 0 is the oldest.
- `inst0Packet_i`..`inst3Packet_i` input PKT_W each: per-slot packet.
- `decodeReady_i` input 1: decode consumes the presented entries this cycle.
- `frontEndWidth_i` input 3: active dispatch width, 1–4. Any other value means 4.
- `fetchqFull_o` output 1: fewer than 4 free entries; fetch must stall.
- `fetchqEmpty_o` output 1: count == 0.
- `count_o` output log2(DEPTH)+1: current occupancy.
- `inst0Valid_o`..`inst3Valid_o` output 1 each: head+k entry is presented.
- `inst0Packet_o`..`inst3Packet_o` output PKT_W each: entry at head+k, modulo DEPTH.
- `fullCycles_o`, `emptyCycles_o` output 32 each: present only under `FETCHQ_STATS_EN`.

## Operation
- **State.** Storage array `DEPTH` × `PKT_W`, with a head pointer and a tail pointer, each log2(DEPTH) bits, wrapping modulo DEPTH. There is also a count register, 0..DEPTH.
- **Write (push).**
  - Occurs when `fs2Ready_i & ~fetchqFull_o & ~flush_i`.
  - Let `nw` = popcount of the valid inputs.
  - Valid slots are written in slot order, with gaps removed, to `tail`, `tail+1`, … (wrapping). `tail` advances by `nw`.
  - When `fetchqFull_o` is high, the whole bundle is refused and upstream holds it. There are no partial writes.
- **Presentation.**
  - `W` = active width from `frontEndWidth_i`.
  - `instkValid_o = (k < min(count, W))`.
  - Packets come combinationally from the registered array at `head+k`.
  - Packet values are don't-care when the corresponding valid is 0.
- **Read (pop).** When `decodeReady_i & ~flush_i`, `nr = min(count, W)` entries leave and `head` advances by `nr`.
- **Simultaneous push and pop.** `count_next = count + nw - nr`.
  - `fetchqFull_o` is computed from the registered count (`DEPTH - count < 4`). It does not credit the same-cycle pop.
- **Flush.** Sets `head = tail = count = 0` next cycle. It overrides any push or pop in the same cycle.
- **Reset.** Same effect as flush.
  - Reset output values: all `instkValid_o` = 0, `fetchqFull_o` = 0, `fetchqEmpty_o` = 1, `count_o` = 0.
  - Stats counters, if present, are 0.

## Timing
- Write-to-read latency is 1 cycle. A packet pushed in cycle t is visible on outputs in t+1. There is no same-cycle bypass.
- All outputs are functions of registers only. There is no combinational path from `decodeReady_i` or the write-side inputs to any output.
- Wrap-around: a bundle that straddles entry DEPTH-1 continues at entry 0 with no bubble.
- Full boundary: at `count = DEPTH-4`, `fetchqFull_o` = 0, so a 4-wide push lands exactly at DEPTH. At `count ≥ DEPTH-3` it is 1.
- Empty boundary: when `count = 0`, all valid outputs are 0 and a pop has no effect.
- A `frontEndWidth_i` change takes effect on presentation and pop in the same cycle. Entries are never lost or reordered.

## Configuration
- `FETCHQ_STATS_EN` defined: two 32-bit saturating counters are built.
  - `fullCycles_o` increments each cycle that `fetchqFull_o & fs2Ready_i`.
  - `emptyCycles_o` increments each cycle that `fetchqEmpty_o`.
  - Both clear on `reset` only, not on flush.
- `FETCHQ_STATS_EN` undefined: the counters and both ports are absent. No other behaviour changes.

## Test plan
- **Basic latency.** Reset; push 4 valid packets with PC tags A..D; hold `decodeReady_i` = 0.
  - Next cycle: `count_o` = 4 and outputs 0–3 show A..D.
  - Then `decodeReady_i` = 1: the queue is empty one cycle later.
- **Compaction.** Push valid pattern 1,0,1,1 (X,–,Y,Z).
  - Outputs 0–2 show X,Y,Z, `inst3Valid_o` = 0, `count_o` = 3.
- **Full and wrap.** Fill to 12 entries with `DEPTH` = 16; push 4 more.
  - `count_o` = 16 and `fetchqFull_o` = 1.
  - A further bundle is refused; `count_o` stays 16.
  - Pop 4 per cycle: order is preserved across the wrap at entry 15→0.
- **Simultaneous push, pop and flush.**
  - `count` = 6, push 3, pop with W = 4: next `count_o` = 5.
  - Same cycle with `flush_i` = 1 instead: next `count_o` = 0 and all valids are 0.
- **Width control.** `frontEndWidth_i` = 2 with 5 entries: only valid 0–1 are asserted and each pop removes 2. With `frontEndWidth_i` = 7: W = 4.
- **Stats (with `FETCHQ_STATS_EN`).** Hold the queue full with `fs2Ready_i` = 1 for 10 cycles: `fullCycles_o` = 10. After reset: `emptyCycles_o` counts from 0.
